// File: rtl/alu_seq_fxp_pkg.sv
// Shared op codes, FSM encoding and signed range helpers for the sequential ALU.
package alu_seq_fxp_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_MULHI = 3'd3,
    OP_MULLO = 3'd4,
    OP_DIV   = 3'd5,
    OP_MOD   = 3'd6,
    OP_OR    = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Most negative w-bit value, sign-extended to 32 bits.
  function automatic logic [31:0] min_of(input int w);
    return 32'hFFFF_FFFF << (w - 1);
  endfunction

  // Most positive w-bit value.
  function automatic logic [31:0] max_of(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/alu_seq_fxp_if.sv
// Operand/result handshake bundle. The slave side is the ALU, the master side
// is the producer/consumer pair that drives operands and accepts results.
interface alu_seq_fxp_if #(parameter int WIDTH = 15);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       command;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             div_zero;

  modport slave  (input  in_valid, command, a, b, out_ready,
                  output in_ready, out_valid, result, ovf, div_zero);
  modport master (output in_valid, command, a, b, out_ready,
                  input  in_ready, out_valid, result, ovf, div_zero);
endinterface

// File: rtl/alu_seq_fxp_iter_core.sv
// Shared iterative datapath: shift-add multiply (i_mode=0) or restoring divide
// (i_mode=1) on unsigned magnitudes, one bit per cycle for WIDTH cycles.
// Accumulator layout: multiply -> {product_hi, product_lo};
// divide -> {remainder, quotient}.
module alu_iter_core #(parameter int WIDTH = 15) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic [WIDTH-1:0]   i_ma,
  input  logic [WIDTH-1:0]   i_mb,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_acc
);
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mb;
  logic               r_mode;
  logic               r_busy;
  logic               r_done;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shr;
  logic [WIDTH:0]     w_dif;
  logic               w_fit;
  logic [2*WIDTH-1:0] w_nxt;

  // One step of either algorithm, selected by the captured mode.
  always_comb begin
    w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mb} : '0);
    w_shr = r_acc[2*WIDTH-1:WIDTH-1];
    w_dif = w_shr - {1'b0, r_mb};
    w_fit = (w_shr >= {1'b0, r_mb});
    if (r_mode)
      w_nxt = {(w_fit ? w_dif[WIDTH-1:0] : w_shr[WIDTH-1:0]), r_acc[WIDTH-2:0], w_fit};
    else
      w_nxt = {w_sum, r_acc[WIDTH-1:1]};
  end

  // Load on start, iterate while busy, pulse done after the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_mb   <= '0;
      r_mode <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_acc  <= {{WIDTH{1'b0}}, i_ma};
        r_mb   <= i_mb;
        r_mode <= i_mode;
        r_busy <= 1'b1;
        r_cnt  <= '0;
      end else if (r_busy) begin
        r_acc <= w_nxt;
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_acc  = r_acc;
endmodule

// File: rtl/alu_seq_fxp.sv
// Sequential signed ALU with valid/ready handshakes, one op in flight.
// Optional build macro ALU_SATURATE_EN: clamp overflowing ADD/SUB/MULLO/DIV
// results to MIN/MAX instead of wrapping (ovf is reported either way).
module alu_seq_fxp
  import alu_seq_fxp_pkg::*;
#(parameter int WIDTH = 15) (
  input  logic           clk,
  input  logic           rst,
  alu_seq_fxp_if.slave   bus
);
  localparam logic [WIDTH-1:0] MIN = WIDTH'(min_of(WIDTH));
  localparam logic [WIDTH-1:0] MAX = WIDTH'(max_of(WIDTH));

  state_e           r_state;
  op_e              r_cmd;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_pend;
  logic             r_ovalid;
  logic [WIDTH-1:0] r_result;
  logic             r_ovf, r_dz;

  logic               w_accept, w_iter_cmd, w_start, w_done;
  logic [WIDTH-1:0]   w_ma, w_mb;
  logic [2*WIDTH-1:0] w_acc, w_prod;
  logic [WIDTH-1:0]   w_sum, w_dif, w_quo, w_rem;
  logic               w_neg, w_bzero, w_minneg;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf, w_dz;

  assign w_accept   = bus.in_valid && (r_state == ST_IDLE);
  assign w_iter_cmd = (bus.command >= 3'd3) && (bus.command <= 3'd6);
  assign w_start    = w_accept && w_iter_cmd;
  assign w_ma       = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign w_mb       = bus.b[WIDTH-1] ? -bus.b : bus.b;

  alu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_mode  (bus.command[2] & (bus.command != 3'd4)),
    .i_ma    (w_ma),
    .i_mb    (w_mb),
    .o_done  (w_done),
    .o_acc   (w_acc)
  );

  // Result, sign fix-up and flags for the captured command.
  always_comb begin
    w_sum    = r_a + r_b;
    w_dif    = r_a - r_b;
    w_neg    = r_a[WIDTH-1] ^ r_b[WIDTH-1];
    w_prod   = w_neg ? -w_acc : w_acc;
    w_quo    = w_neg ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
    w_rem    = r_a[WIDTH-1] ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];
    w_bzero  = (r_b == '0);
    w_minneg = (r_a == MIN) && (r_b == '1);
    w_res    = '0;
    w_ovf    = 1'b0;
    w_dz     = 1'b0;
    case (r_cmd)
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
`ifdef ALU_SATURATE_EN
        if (w_ovf) w_res = r_a[WIDTH-1] ? MIN : MAX;
`endif
      end
      OP_SUB: begin
        w_res = w_dif;
        w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_dif[WIDTH-1] != r_a[WIDTH-1]);
`ifdef ALU_SATURATE_EN
        if (w_ovf) w_res = r_a[WIDTH-1] ? MIN : MAX;
`endif
      end
      OP_AND:   w_res = r_a & r_b;
      OP_OR:    w_res = r_a | r_b;
      OP_MULHI: w_res = w_prod[2*WIDTH-1:WIDTH];
      OP_MULLO: begin
        w_res = w_prod[WIDTH-1:0];
        w_ovf = (w_prod[2*WIDTH-1:WIDTH-1] != '0) && (w_prod[2*WIDTH-1:WIDTH-1] != '1);
`ifdef ALU_SATURATE_EN
        if (w_ovf) w_res = w_prod[2*WIDTH-1] ? MIN : MAX;
`endif
      end
      OP_DIV: begin
        w_dz = w_bzero;
        if (w_bzero) w_res = r_a[WIDTH-1] ? MIN : MAX;
        else if (w_minneg) begin
          w_ovf = 1'b1;
`ifdef ALU_SATURATE_EN
          w_res = MAX;
`else
          w_res = MIN;
`endif
        end else w_res = w_quo;
      end
      OP_MOD: begin
        w_dz = w_bzero;
        if (w_bzero) w_res = r_a;
        else         w_res = w_rem;
      end
      default: ;
    endcase
  end

  // Handshake FSM with operand capture and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cmd    <= OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_pend   <= 1'b0;
      r_ovalid <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.in_valid) begin
          r_cmd <= op_e'(bus.command);
          r_a   <= bus.a;
          r_b   <= bus.b;
          if (w_iter_cmd) r_state <= ST_CALC;
          else begin
            r_state <= ST_DONE;
            r_pend  <= 1'b1;
          end
        end
        ST_CALC: if (w_done) begin
          r_result <= w_res;
          r_ovf    <= w_ovf;
          r_dz     <= w_dz;
          r_ovalid <= 1'b1;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          if (r_pend) begin
            r_result <= w_res;
            r_ovf    <= w_ovf;
            r_dz     <= w_dz;
            r_ovalid <= 1'b1;
            r_pend   <= 1'b0;
          end else if (bus.out_ready) begin
            r_ovalid <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = r_ovalid;
  assign bus.result    = r_result;
  assign bus.ovf       = r_ovf;
  assign bus.div_zero  = r_dz;
endmodule

// File: tb/tb_alu_seq_fxp.sv
// Directed bench for alu_seq_fxp at WIDTH=15.
// Build with ALU_SATURATE_EN defined to check the clamping variant.
module tb_alu_seq_fxp;
  localparam int W = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_seq_fxp_if #(.WIDTH(W)) bus();
  alu_seq_fxp #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, scramble operands after accept, wait for result (not consumed).
  task automatic issue(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat);
    int guard = 0;
    while (!bus.in_ready && guard < 100) begin tick(); guard++; end
    if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.command = c; bus.a = x; bus.b = y;
    tick();
    bus.in_valid = 1'b0; bus.a = 15'h5A5A; bus.b = 15'h2323; bus.command = 3'd0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin tick(); lat++; end
    if (!bus.out_valid) chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic op(input string tag, input logic [2:0] c, input logic [W-1:0] x,
                    input logic [W-1:0] y, input logic [W-1:0] er, input logic eo,
                    input logic ed);
    int lat;
    issue(c, x, y, lat);
    chk({tag, "_res"}, 32'(bus.result), 32'(er));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
    chk({tag, "_dz"},  32'(bus.div_zero), 32'(ed));
    chk({tag, "_lat"}, lat, (c >= 3'd3 && c <= 3'd6) ? 16 : 1);
    consume();
  endtask

  initial begin
    int lat;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.command = '0; bus.a = '0; bus.b = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result",    32'(bus.result), 32'd0);
    chk("rst_ovf",       32'(bus.ovf), 32'd0);
    chk("rst_dz",        32'(bus.div_zero), 32'd0);

    op("add",   3'd0, 15'd100, 15'h7FE2, 15'd70,   1'b0, 1'b0);
    op("mullo", 3'd4, 15'h7FFD, 15'd5,   15'h7FF1, 1'b0, 1'b0);
    op("mulhi", 3'd3, 15'h7FFD, 15'd5,   15'h7FFF, 1'b0, 1'b0);
    op("div",   3'd5, 15'h7FF9, 15'd2,   15'h7FFD, 1'b0, 1'b0);
    op("mod",   3'd6, 15'h7FF9, 15'd2,   15'h7FFF, 1'b0, 1'b0);
    op("div0",  3'd5, 15'd9,    15'd0,   15'h3FFF, 1'b0, 1'b1);
    op("mod0",  3'd6, 15'd9,    15'd0,   15'd9,    1'b0, 1'b1);
    op("and",   3'd2, 15'h0F0F, 15'h00FF, 15'h000F, 1'b0, 1'b0);
    op("or",    3'd7, 15'h0F0F, 15'h00FF, 15'h0FFF, 1'b0, 1'b0);
    op("modmn", 3'd6, 15'h4000, 15'h7FFF, 15'd0,   1'b0, 1'b0);
`ifdef ALU_SATURATE_EN
    op("addov", 3'd0, 15'h3FFF, 15'd1,   15'h3FFF, 1'b1, 1'b0);
    op("subov", 3'd1, 15'h4000, 15'd1,   15'h4000, 1'b1, 1'b0);
    op("mulov", 3'd4, 15'd200,  15'd200, 15'h3FFF, 1'b1, 1'b0);
    op("divmn", 3'd5, 15'h4000, 15'h7FFF, 15'h3FFF, 1'b1, 1'b0);
`else
    op("addov", 3'd0, 15'h3FFF, 15'd1,   15'h4000, 1'b1, 1'b0);
    op("subov", 3'd1, 15'h4000, 15'd1,   15'h3FFF, 1'b1, 1'b0);
    op("mulov", 3'd4, 15'd200,  15'd200, 15'h1C40, 1'b1, 1'b0);
    op("divmn", 3'd5, 15'h4000, 15'h7FFF, 15'h4000, 1'b1, 1'b0);
`endif

    // Backpressure: result held, second request ignored.
    issue(3'd0, 15'd1, 15'd1, lat);
    chk("bp_lat", lat, 1);
    bus.in_valid = 1'b1; bus.command = 3'd0; bus.a = 15'd7; bus.b = 15'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_result", 32'(bus.result), 32'd2);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    consume();
    chk("bp_rel_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_rel_out_valid", 32'(bus.out_valid), 32'd0);
    tick(); tick();
    chk("bp_no_ghost", 32'(bus.out_valid), 32'd0);

    // Reset five cycles into a divide abandons it.
    bus.in_valid = 1'b1; bus.command = 3'd5; bus.a = 15'd100; bus.b = 15'd7;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_in_ready",  32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 20; i++) tick();
    chk("rst_mid_no_result", 32'(bus.out_valid), 32'd0);
    op("add_post", 3'd0, 15'd2, 15'd3, 15'd5, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
